// File: rtl/timer_pkg.sv
// Shared types and default widths for the interval timer.
package timer_pkg;

  localparam int TIMER_WIDTH       = 16;
  localparam int TIMER_PRESC_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running divider: strobe on the enabled cycle where the phase counter equals div, then wrap.
// Phase is frozen while enable is low; clear forces phase back to 0.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int W = TIMER_PRESC_WIDTH
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] div,
  output logic         strobe
);

  logic [W-1:0] phase_q;

  assign strobe = enable && (phase_q == div);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      phase_q <= '0;
    end else if (clear) begin
      phase_q <= '0;
    end else if (enable) begin
      phase_q <= strobe ? '0 : phase_q + 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Programmable interval timer with one-shot/auto-reload and pause; all outputs registered.
// Prescaler is built only when INTERVAL_TIMER_PRESCALER_EN is defined, otherwise every RUN cycle strobes.
module interval_timer
  import timer_pkg::*;
#(
  parameter int WIDTH       = TIMER_WIDTH,
  parameter int PRESC_WIDTH = TIMER_PRESC_WIDTH
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   pause,
  input  logic                   auto_reload,
  input  logic [WIDTH-1:0]       period,
  input  logic [PRESC_WIDTH-1:0] presc_div,
  input  logic                   done_clr,
  output logic                   tick,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  timer_state_e     state_q, state_nx;
  logic [WIDTH-1:0] count_q, count_nx;
  logic [WIDTH-1:0] period_q;
  logic             reload_q;
  logic             tick_q, tick_nx;
  logic             busy_q;
  logic             done_q, done_set;

  logic active, load, advance, strobe;

  assign active = (state_q != IDLE);
  // A zero-period start is treated as absent; stop outranks start.
  assign load    = start && (period != '0) && !stop;
  assign advance = active && !pause && !stop && !load;

`ifdef INTERVAL_TIMER_PRESCALER_EN
  logic [PRESC_WIDTH-1:0] div_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      div_q <= '0;
    end else if (load) begin
      div_q <= presc_div;
    end
  end

  timer_prescaler #(
    .W (PRESC_WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .clrn   (clrn),
    .clear  (load),
    .enable (advance),
    .div    (div_q),
    .strobe (strobe)
  );
`else
  logic unused_presc_div;

  assign unused_presc_div = ^presc_div;
  assign strobe           = advance;
`endif

  always_comb begin
    state_nx = state_q;
    count_nx = count_q;
    tick_nx  = 1'b0;
    done_set = 1'b0;
    if (stop) begin
      if (active) state_nx = IDLE;
    end else if (load) begin
      state_nx = RUN;
      count_nx = period;
    end else if (active && pause) begin
      state_nx = PAUSE;
    end else if (active) begin
      // Releasing pause counts in the same cycle, so the delay equals the pause length.
      state_nx = RUN;
      if (strobe) begin
        if (count_q == ONE) begin
          tick_nx  = 1'b1;
          done_set = 1'b1;
          if (reload_q) begin
            count_nx = period_q;
          end else begin
            count_nx = '0;
            state_nx = IDLE;
          end
        end else begin
          count_nx = count_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      reload_q <= 1'b0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      count_q <= count_nx;
      tick_q  <= tick_nx;
      busy_q  <= (state_nx != IDLE);
      done_q  <= done_set | (done_q & ~done_clr);
      if (load) begin
        period_q <= period;
        reload_q <= auto_reload;
      end
    end
  end

  assign tick  = tick_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed self-checking bench for interval_timer; expectations follow the build's prescaler setting.
module tb_interval_timer;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic        auto_reload = 1'b0;
  logic [15:0] period = '0;
  logic [7:0]  presc_div = '0;
  logic        done_clr = 1'b0;
  logic        tick, busy, done;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;

  interval_timer dut (
    .clk         (clk),
    .clrn        (clrn),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .auto_reload (auto_reload),
    .period      (period),
    .presc_div   (presc_div),
    .done_clr    (done_clr),
    .tick        (tick),
    .busy        (busy),
    .done        (done),
    .count       (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Cycles per prescaled tick for a given divider in this build.
  function automatic int cyc_per_tick(input int d);
`ifdef INTERVAL_TIMER_PRESCALER_EN
    return d + 1;
`else
    return 1;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the edge that samples start (edge 0).
  task automatic start_timer(input logic [15:0] p, input logic [7:0] d, input logic ar);
    period      = p;
    presc_div   = d;
    auto_reload = ar;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic clear_done();
    done_clr = 1'b1;
    step();
    done_clr = 1'b0;
  endtask

  task automatic test_reset();
    int tick_seen;
    clrn = 1'b0;
    step();
    step();
    checks++; if (tick !== 1'b0)   begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    clrn = 1'b1;
    step();
    start_timer(16'd10, 8'd0, 1'b0);
    for (int i = 0; i < 20 && count !== 16'd4; i++) step();
    checks++; if (count !== 16'd4) begin errors++; $display("FAIL reset_reach_count4: got %0d want 4", count); end
    #2 clrn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || count !== 16'd0 || tick !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL reset_async: busy=%b count=%0d tick=%b done=%b want all 0", busy, count, tick, done); end
    step();
    clrn = 1'b1;
    tick_seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (tick !== 1'b0 || busy !== 1'b0) tick_seen++;
    end
    checks++; if (tick_seen !== 0) begin errors++; $display("FAIL reset_no_activity: %0d active cycles want 0", tick_seen); end
  endtask

  task automatic test_one_shot();
    start_timer(16'd3, 8'd0, 1'b0);
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL oneshot_busy_e0: got %b want 1", busy); end
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL oneshot_count_e0: got %0d want 3", count); end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (tick !== (k == 3)) begin errors++; $display("FAIL oneshot_tick_e%0d: got %b want %b", k, tick, (k == 3)); end
      checks++; if (busy !== (k < 3))  begin errors++; $display("FAIL oneshot_busy_e%0d: got %b want %b", k, busy, (k < 3)); end
      checks++; if (done !== (k >= 3)) begin errors++; $display("FAIL oneshot_done_e%0d: got %b want %b", k, done, (k >= 3)); end
      checks++; if (count !== 16'((k < 3) ? 3 - k : 0))
        begin errors++; $display("FAIL oneshot_count_e%0d: got %0d want %0d", k, count, (k < 3) ? 3 - k : 0); end
    end
    clear_done();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL oneshot_done_clr: got %b want 0", done); end
  endtask

  task automatic test_auto_reload();
    int d, len, n, last_k, bad;
    d   = cyc_per_tick(2);
    len = 4 * d;
    bad = 0;
    start_timer(16'd4, 8'd2, 1'b1);
    last_k = 5 * len + 1;
    for (int k = 0; k <= last_k; k++) begin
      if (k > 0) step();
      n = k / d;
      checks++; if (count !== 16'(4 - (n % 4)))
        begin errors++; $display("FAIL autoreload_count_e%0d: got %0d want %0d", k, count, 4 - (n % 4)); end
      checks++; if (tick !== (k > 0 && (k % len) == 0))
        begin errors++; $display("FAIL autoreload_tick_e%0d: got %b want %b", k, tick, (k > 0 && (k % len) == 0)); end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n = last_k / d;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL autoreload_stop_busy: got %b want 0", busy); end
    checks++; if (count !== 16'(4 - (n % 4)))
      begin errors++; $display("FAIL autoreload_stop_count: got %0d want %0d", count, 4 - (n % 4)); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL autoreload_stop_tick: got %b want 0", tick); end
    clear_done();
  endtask

  task automatic test_pause();
    start_timer(16'd5, 8'd0, 1'b0);
    step(); step(); step();
    checks++; if (count !== 16'd2) begin errors++; $display("FAIL pause_pre_count: got %0d want 2", count); end
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++; if (count !== 16'd2 || busy !== 1'b1 || tick !== 1'b0)
        begin errors++; $display("FAIL pause_hold_%0d: count=%0d busy=%b tick=%b want 2/1/0", i, count, busy, tick); end
    end
    pause = 1'b0;
    step();
    checks++; if (count !== 16'd1 || tick !== 1'b0)
      begin errors++; $display("FAIL pause_resume: count=%0d tick=%b want 1/0", count, tick); end
    step();
    checks++; if (tick !== 1'b1 || busy !== 1'b0 || count !== 16'd0)
      begin errors++; $display("FAIL pause_expiry: tick=%b busy=%b count=%0d want 1/0/0", tick, busy, count); end
    clear_done();
  endtask

  task automatic test_stop_expiry();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stopexp_done_pre: got %b want 0", done); end
    start_timer(16'd2, 8'd0, 1'b0);
    step();
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL stopexp_count_pre: got %0d want 1", count); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (tick !== 1'b0)   begin errors++; $display("FAIL stopexp_tick: got %b want 0", tick); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL stopexp_done: got %b want 0", done); end
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL stopexp_count: got %0d want 1", count); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL stopexp_busy: got %b want 0", busy); end
    step();
    checks++; if (tick !== 1'b0)   begin errors++; $display("FAIL stopexp_late_tick: got %b want 0", tick); end
    period = 16'd0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    checks++; if (busy !== 1'b0 || count !== 16'd1)
      begin errors++; $display("FAIL zero_period_start: busy=%b count=%0d want 0/1", busy, count); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_period_later: busy=%b want 0", busy); end
  endtask

  task automatic test_restart_expiry();
    start_timer(16'd2, 8'd0, 1'b0);
    step();
    start_timer(16'd3, 8'd0, 1'b0);
    checks++; if (tick !== 1'b0 || count !== 16'd3 || busy !== 1'b1 || done !== 1'b0)
      begin errors++; $display("FAIL restart_expiry: tick=%b count=%0d busy=%b done=%b want 0/3/1/0", tick, count, busy, done); end
    step(); step();
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL restart_count: got %0d want 1", count); end
    done_clr = 1'b1;
    step();
    done_clr = 1'b0;
    checks++; if (tick !== 1'b1 || done !== 1'b1)
      begin errors++; $display("FAIL done_set_over_clr: tick=%b done=%b want 1/1", tick, done); end
    step();
    checks++; if (done !== 1'b1 || tick !== 1'b0)
      begin errors++; $display("FAIL done_sticky: done=%b tick=%b want 1/0", done, tick); end
    clear_done();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_cleared: got %b want 0", done); end
  endtask

  task automatic test_prescaler_config();
    int d;
    d = cyc_per_tick(5);
    start_timer(16'd2, 8'd5, 1'b0);
    for (int k = 1; k <= 2 * d + 1; k++) begin
      step();
      checks++; if (tick !== (k == 2 * d))
        begin errors++; $display("FAIL presc_cfg_tick_e%0d: got %b want %b", k, tick, (k == 2 * d)); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL presc_cfg_busy_end: got %b want 0", busy); end
    clear_done();
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_stop_expiry();
    test_restart_expiry();
    test_prescaler_config();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
# interval_timer

Programmable interval timer producing single-cycle `tick` strobes at a period of `period × (presc_div+1)` clock cycles, in one-shot or auto-reload mode. It is the stage directly upstream of the general-purpose event counters: `tick` drives a counter's count-enable input, and `busy`/`done` are exposed for control/status registers.

## Interface
- `WIDTH`, 16, width of period and count
- `PRESC_WIDTH`, 8, width of prescaler divider
- `clk`  in  1  clock
- `clrn`  in  1  reset, asynchronous, active-low
- `start`  in  1  pulse; loads `period`, clears prescaler, enters RUN
- `stop`  in  1  pulse; aborts to IDLE
- `pause`  in  1  level; freezes count and prescaler while high in RUN
- `auto_reload`  in  1  level; sampled at start; 1 = periodic, 0 = one-shot
- `period`  in  WIDTH  ticks per interval; sampled at start only
- `presc_div`  in  PRESC_WIDTH  prescaler divide-minus-one; sampled at start
- `done_clr`  in  1  pulse; clears `done`
- `tick`  out  1  one-cycle expiry strobe, registered
- `busy`  out  1  high in RUN or PAUSE
- `done`  out  1  sticky expiry flag
- `count`  out  WIDTH  remaining prescaled ticks in the current interval

## Operation
- FSM states: IDLE, RUN, PAUSE.
- IDLE: `start` with `period`≠0 → RUN; `count`←`period`; prescaler←0; `period`, `presc_div` and `auto_reload` latched internally. `start` with `period`=0 is ignored.
- RUN: the prescaler counts 0..presc_div and emits a strobe on the cycle it equals presc_div, then wraps to 0. Each strobe decrements `count`.
- Strobe with `count`=1 is an expiry:
  - `tick`←1 for one cycle; `done`←1.
  - If latched auto_reload=1: `count`←latched period, stay in RUN.
  - Else: `count`←0 → IDLE.
- `pause`=1 in RUN → PAUSE (prescaler and count frozen). `pause`=0 in PAUSE → RUN, resuming the same prescaler phase.
- `stop` in RUN or PAUSE → IDLE. `count` holds its value; no tick is emitted.
- `start` in RUN or PAUSE restarts: the same actions as from IDLE, and the state becomes RUN.
- Priority: stop > start > pause > expiry.
  - Stop and expiry in the same cycle: no tick, no done.
  - Start and expiry in the same cycle: restart, no tick.
- `done`: set has priority over `done_clr` in the same cycle.
- Arithmetic: the count decrement never wraps; `count` in RUN is always ≥1. The prescaler compare is an unsigned equality.

## Timing
- Reset: state IDLE, `count`=0, prescaler=0, `tick`=0, `busy`=0, `done`=0, latched registers=0.
- `start` sampled at edge N → `busy`=1 and `count`=period from N+1.
- With presc_div=0, every RUN cycle is a strobe. In one-shot mode with period=P, `tick` is high in the cycle after edge N+P, and `busy` falls in that same cycle.
- Auto-reload: ticks are spaced exactly P×(presc_div+1) cycles apart with no gap cycle.
- `stop`/`pause` take effect on the next edge; the cycle in which they are sampled does not count.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `INTERVAL_TIMER_PRESCALER_EN`:
  - Defined: prescaler operates as above.
  - Undefined: the prescaler is not built, the `presc_div` port remains but is ignored, and a strobe occurs every RUN cycle (equivalent to presc_div=0).

## Structure
- Package `timer_pkg`: `timer_state_e` enum (IDLE, RUN, PAUSE); localparam default widths.
- Sub-module `timer_prescaler`:
  - Inputs: clk, clrn, clear, enable, div.
  - Output: strobe.
  - Instantiated only under `INTERVAL_TIMER_PRESCALER_EN`.

## Test plan
- Reset mid-RUN (period=10, clrn low at count=4) → all outputs 0, IDLE immediately; no tick after release.
- One-shot, period=3, presc_div=0, start at edge 0 → tick high in the cycle after edge 3 only; busy 1→0 in that cycle; done=1 until done_clr.
- Auto-reload, period=4, presc_div=2 → ticks every 12 cycles for ≥5 intervals; count sequence 4,4,4,3,3,3,…
- Pause for 7 cycles at count=2 (period=5, presc_div=0) → expiry delayed by exactly 7 cycles; count and prescaler unchanged during PAUSE.
- Stop in the same cycle as expiry → no tick, done stays 0, count holds 1; start with period=0 from IDLE → no state change.
- Macro undefined, presc_div=5, period=2 → tick after 2 cycles, as if presc_div=0.
